// File: rtl/md_pkg.sv
// md_pkg: shared types and constants for the multiply/divide unit.
// Optional feature macro: MD_MADD_EN (enables MADD/MSUB accumulate encodings).
package md_pkg;

  localparam int unsigned DATA_W          = 32;
  localparam int unsigned OP_W            = 3;
  localparam int unsigned CNT_W           = 4;
  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  // Operation select encodings carried on MDOp
  typedef enum logic [OP_W-1:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5,
    MD_MADD  = 3'd6,
    MD_MSUB  = 3'd7
  } mdOp_e;

  // Build-time choice: accumulate ops act as maddu/msubu when set
  localparam bit MD_ACC_UNSIGNED = 1'b0;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mdState_e;

  // 64-bit mult/div result as it lands in HI/LO
  typedef struct packed {
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
  } mdResult_t;

endpackage

// File: rtl/md_unit_if.sv
// md_unit_if: E-stage request/response bundle for md_unit.
//   master (pipeline): drives Start, MDOp, A, B, WriteHL; observes Busy, HI, LO
//   slave  (md_unit) : the reverse
interface md_unit_if;
  import md_pkg::*;

  logic              Start;
  logic [OP_W-1:0]   MDOp;
  logic [DATA_W-1:0] A;
  logic [DATA_W-1:0] B;
  logic              WriteHL;
  logic              Busy;
  logic [DATA_W-1:0] HI;
  logic [DATA_W-1:0] LO;

  modport master (output Start, MDOp, A, B, WriteHL, input Busy, HI, LO);
  modport slave  (input Start, MDOp, A, B, WriteHL, output Busy, HI, LO);

endinterface

// File: rtl/md_calc.sv
// md_calc: combinational 64-bit multiply/divide result.
//   mdOp     : operation select (md_pkg encodings)
//   a, b     : rs / rt operands
//   result_c : {HI, LO} value the operation produces
//   valid_c  : mdOp is a multi-cycle operation in this build
//   isDiv_c  : operation uses the divide latency
// With MD_MADD_EN defined, MADD/MSUB return the raw product; the
// accumulate against HI/LO happens at commit in md_unit.
module md_calc
  import md_pkg::*;
(
  input  logic [OP_W-1:0]   mdOp,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output mdResult_t         result_c,
  output logic              valid_c,
  output logic              isDiv_c
);

  logic signed [2*DATA_W-1:0] prodS;
  logic        [2*DATA_W-1:0] prodU;
  logic signed [DATA_W-1:0]   aS;
  logic signed [DATA_W-1:0]   bS;
  logic        [DATA_W-1:0]   qS, rS, qU, rU;
  logic                       divZero;
  logic                       divOvf;

  assign aS    = $signed(a);
  assign bS    = $signed(b);
  assign prodS = $signed({{DATA_W{a[DATA_W-1]}}, a}) * $signed({{DATA_W{b[DATA_W-1]}}, b});
  assign prodU = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};

  assign divZero = (b == '0);
  // Most-negative / -1 overflows the 32-bit quotient; pinned explicitly
  assign divOvf  = (a == DATA_W'(32'h8000_0000)) && (b == '1);

  // Quotients/remainders; divide operators only evaluated with a safe divisor
  always_comb begin
    qS = '0;
    rS = '0;
    qU = '0;
    rU = '0;
    if (!divZero) begin
      qU = a / b;
      rU = a % b;
      if (divOvf) begin
        qS = DATA_W'(32'h8000_0000);
        rS = '0;
      end else begin
        qS = aS / bS;
        rS = aS % bS;
      end
    end
  end

  // Result select per operation
  always_comb begin
    result_c = '0;
    valid_c  = 1'b0;
    isDiv_c  = 1'b0;
    case (mdOp)
      MD_MULT: begin
        result_c = mdResult_t'(prodS);
        valid_c  = 1'b1;
      end
      MD_MULTU: begin
        result_c = mdResult_t'(prodU);
        valid_c  = 1'b1;
      end
      MD_DIV: begin
        result_c = divZero ? '{hi: a, lo: '1} : '{hi: rS, lo: qS};
        valid_c  = 1'b1;
        isDiv_c  = 1'b1;
      end
      MD_DIVU: begin
        result_c = divZero ? '{hi: a, lo: '1} : '{hi: rU, lo: qU};
        valid_c  = 1'b1;
        isDiv_c  = 1'b1;
      end
`ifdef MD_MADD_EN
      MD_MADD, MD_MSUB: begin
        result_c = MD_ACC_UNSIGNED ? mdResult_t'(prodU) : mdResult_t'(prodS);
        valid_c  = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// md_unit: E-stage multiply/divide unit with HI/LO registers.
//   Clk, Reset : clock, async active-low reset
//   md (slave) : Start/MDOp/A/B/WriteHL in; Busy/HI/LO out (all registered)
// Optional feature macro: MD_MADD_EN adds MADD/MSUB accumulating into HI/LO.
module md_unit
  import md_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic    Clk,
  input  logic    Reset,
  md_unit_if.slave md
);

  mdState_e         state, nextState;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] loadCount;
  mdResult_t        shadow;
  mdResult_t        commitValue;
  logic             busyReg;
  logic [DATA_W-1:0] hiReg, loReg;

  mdResult_t calcResult;
  logic      calcValid;
  logic      calcIsDiv;

  logic doStart, doCommit, doWriteHi, doWriteLo;

  md_calc uCalc (
    .mdOp     (md.MDOp),
    .a        (md.A),
    .b        (md.B),
    .result_c (calcResult),
    .valid_c  (calcValid),
    .isDiv_c  (calcIsDiv)
  );

  assign loadCount = calcIsDiv ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);

  // State register
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= nextState;
  end

  // Next-state logic
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (md.Start && calcValid) nextState = BUSY;
      BUSY:    if (count == CNT_W'(1))    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Control strobes; Start shadows WriteHL, and both are ignored while busy
  always_comb begin
    doStart   = 1'b0;
    doCommit  = 1'b0;
    doWriteHi = 1'b0;
    doWriteLo = 1'b0;
    case (state)
      IDLE: begin
        doStart   = md.Start && calcValid;
        doWriteHi = !md.Start && md.WriteHL && (md.MDOp == MD_MTHI);
        doWriteLo = !md.Start && md.WriteHL && (md.MDOp == MD_MTLO);
      end
      BUSY:    doCommit = (count == CNT_W'(1));
      default: ;
    endcase
  end

`ifdef MD_MADD_EN
  logic accOp, subOp;

  // Remember whether the in-flight op accumulates into HI/LO
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      accOp <= 1'b0;
      subOp <= 1'b0;
    end else if (doStart) begin
      accOp <= (md.MDOp == MD_MADD) || (md.MDOp == MD_MSUB);
      subOp <= (md.MDOp == MD_MSUB);
    end
  end

  // Accumulate uses HI/LO as they stand at commit, not at issue
  always_comb begin
    if (!accOp)     commitValue = shadow;
    else if (subOp) commitValue = mdResult_t'({hiReg, loReg} - shadow);
    else            commitValue = mdResult_t'({hiReg, loReg} + shadow);
  end
`else
  assign commitValue = shadow;
`endif

  // Datapath: counter, shadow result, Busy, HI/LO
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      count   <= '0;
      shadow  <= '0;
      busyReg <= 1'b0;
      hiReg   <= '0;
      loReg   <= '0;
    end else begin
      busyReg <= (nextState == BUSY);
      if (doStart) begin
        shadow <= calcResult;
        count  <= loadCount;
      end else if (state == BUSY) begin
        count <= count - CNT_W'(1);
      end
      if (doCommit) begin
        hiReg <= commitValue.hi;
        loReg <= commitValue.lo;
      end else if (doWriteHi) begin
        hiReg <= md.A;
      end else if (doWriteLo) begin
        loReg <= md.A;
      end
    end
  end

  assign md.Busy = busyReg;
  assign md.HI   = hiReg;
  assign md.LO   = loReg;

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: self-checking bench for md_unit (table vectors, hand-written
// corner sequences, random ops against an arithmetic reference model).
module tb_md_unit;
  import md_pkg::*;

  logic Clk = 1'b0;
  logic Reset;
  int   nChecks = 0;
  int   nPass   = 0;
  int   nProtocolErr = 0;
  logic [31:0] mHi, mLo;

  always #5 Clk = ~Clk;

  md_unit_if bus ();

  md_unit dut (
    .Clk   (Clk),
    .Reset (Reset),
    .md    (bus.slave)
  );

  // Issue while busy is a stall-unit bug; flag it
  always @(posedge Clk) begin
    if (Reset === 1'b1 && bus.Busy === 1'b1 && (bus.Start === 1'b1 || bus.WriteHL === 1'b1)) begin
      nProtocolErr++;
      $display("FAIL protocol: Start/WriteHL asserted while Busy at %0t", $time);
    end
  end

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expHi;
    logic [31:0] expLo;
    int          cycles;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got %h, expected %h", name, got, exp);
  endtask

  // Reference: plain 64-bit arithmetic on sign/zero-extended operands
  function automatic logic [63:0] refResult(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [63:0] acc);
    longint sa, sb, q, r;
    longint unsigned ua, ub, uq, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (op)
      3'd0: return sa * sb;
      3'd1: return ua * ub;
      3'd2: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      3'd3: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        uq = ua / ub;
        ur = ua % ub;
        return {ur[31:0], uq[31:0]};
      end
      3'd6: return acc + sa * sb;
      3'd7: return acc - sa * sb;
      default: return acc;
    endcase
  endfunction

  function automatic int refCycles(input logic [2:0] op);
    return (op == 3'd2 || op == 3'd3) ? 10 : 5;
  endfunction

  // Issue one op at a negedge; count Busy cycles, watch HI/LO hold meanwhile
  task automatic runOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int cycles, output bit held);
    logic [31:0] h0, l0;
    h0 = bus.HI;
    l0 = bus.LO;
    held = 1'b1;
    bus.Start = 1'b1;
    bus.MDOp  = op;
    bus.A     = a;
    bus.B     = b;
    @(negedge Clk);
    bus.Start = 1'b0;
    bus.A     = $urandom;
    bus.B     = $urandom;
    cycles = 0;
    while (bus.Busy === 1'b1 && cycles < 40) begin
      if (bus.HI !== h0 || bus.LO !== l0) held = 1'b0;
      cycles++;
      @(negedge Clk);
    end
  endtask

  task automatic writeHL(input logic [2:0] op, input logic [31:0] a);
    bus.WriteHL = 1'b1;
    bus.MDOp    = op;
    bus.A       = a;
    @(negedge Clk);
    bus.WriteHL = 1'b0;
    if (op == 3'd4) mHi = a;
    else            mLo = a;
    check("mtx_busy", {63'b0, bus.Busy}, 64'd0);
    check(op == 3'd4 ? "mthi" : "mtlo", {bus.HI, bus.LO}, {mHi, mLo});
  endtask

  task automatic noOpIssue(input logic [2:0] op, input logic wr);
    bus.Start   = 1'b1;
    bus.WriteHL = wr;
    bus.MDOp    = op;
    bus.A       = 32'hA5A5_0001;
    bus.B       = 32'h0000_0003;
    @(negedge Clk);
    bus.Start   = 1'b0;
    bus.WriteHL = 1'b0;
    check("noop_busy", {63'b0, bus.Busy}, 64'd0);
    @(negedge Clk);
    check("noop_hilo", {bus.HI, bus.LO}, {mHi, mLo});
  endtask

  initial begin
    int  cyc;
    bit  held;
    logic [63:0] exp;
    logic [2:0]  op;
    logic [31:0] a, b;

    vecs[0] = '{3'd0, 32'hFFFF_FFFF, 32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFE, 5};
    vecs[1] = '{3'd1, 32'hFFFF_FFFF, 32'd2,          32'h0000_0001, 32'hFFFF_FFFE, 5};
    vecs[2] = '{3'd2, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
    vecs[3] = '{3'd3, 32'd7,         32'd2,          32'd1,         32'd3,         10};
    vecs[4] = '{3'd3, 32'h0000_1234, 32'd0,          32'h0000_1234, 32'hFFFF_FFFF, 10};
    vecs[5] = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF,  32'd0,         32'h8000_0000, 10};
    vecs[6] = '{3'd2, 32'd7,         32'hFFFF_FFFE,  32'd1,         32'hFFFF_FFFD, 10};
    vecs[7] = '{3'd2, 32'hFFFF_FFF9, 32'd0,          32'hFFFF_FFF9, 32'hFFFF_FFFF, 10};

    bus.Start = 1'b0; bus.WriteHL = 1'b0; bus.MDOp = '0; bus.A = '0; bus.B = '0;
    Reset = 1'b0;
    mHi = '0;
    mLo = '0;
    #2;
    check("reset_busy", {63'b0, bus.Busy}, 64'd0);
    check("reset_hilo", {bus.HI, bus.LO}, 64'd0);
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);

    // Table vectors
    for (int i = 0; i < 8; i++) begin
      runOp(vecs[i].op, vecs[i].a, vecs[i].b, cyc, held);
      check($sformatf("vec%0d_cycles", i), 64'(cyc), 64'(vecs[i].cycles));
      check($sformatf("vec%0d_hilo", i), {bus.HI, bus.LO}, {vecs[i].expHi, vecs[i].expLo});
      check($sformatf("vec%0d_hold", i), {63'b0, held}, 64'd1);
      mHi = vecs[i].expHi;
      mLo = vecs[i].expLo;
    end

    // mthi / mtlo
    writeHL(3'd4, 32'hDEAD_BEEF);
    writeHL(3'd5, 32'h0000_0005);

    // Start wins over WriteHL; invalid Start ops do nothing
    noOpIssue(3'd4, 1'b1);
    noOpIssue(3'd5, 1'b0);
`ifndef MD_MADD_EN
    noOpIssue(3'd6, 1'b0);
    noOpIssue(3'd7, 1'b0);
`endif

    // Reset mid-operation: abort, no stale commit
    bus.Start = 1'b1; bus.MDOp = 3'd0; bus.A = 32'd3; bus.B = 32'd4;
    @(negedge Clk);
    bus.Start = 1'b0;
    @(negedge Clk);
    Reset = 1'b0;
    #1;
    mHi = '0;
    mLo = '0;
    check("abort_busy", {63'b0, bus.Busy}, 64'd0);
    check("abort_hilo", {bus.HI, bus.LO}, 64'd0);
    @(negedge Clk);
    Reset = 1'b1;
    repeat (8) @(negedge Clk);
    check("abort_after_busy", {63'b0, bus.Busy}, 64'd0);
    check("abort_after_hilo", {bus.HI, bus.LO}, 64'd0);

`ifdef MD_MADD_EN
    writeHL(3'd4, 32'd0);
    writeHL(3'd5, 32'hFFFF_FFFF);
    runOp(3'd6, 32'd1, 32'd1, cyc, held);
    check("madd_cycles", 64'(cyc), 64'd5);
    check("madd_hilo", {bus.HI, bus.LO}, {32'd1, 32'd0});
    runOp(3'd7, 32'd1, 32'd1, cyc, held);
    check("msub_cycles", 64'(cyc), 64'd5);
    check("msub_hilo", {bus.HI, bus.LO}, {32'd0, 32'hFFFF_FFFF});
    mHi = 32'd0;
    mLo = 32'hFFFF_FFFF;
`endif

    // Random ops against the reference model
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        writeHL($urandom_range(0, 1) ? 3'd4 : 3'd5, $urandom);
      end else begin
        op = 3'($urandom_range(0, 3));
        a  = $urandom;
        b  = $urandom;
        case ($urandom_range(0, 7))
          0: b = 32'd0;
          1: b = 32'($urandom_range(1, 9));
          2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
          default: ;
        endcase
        exp = refResult(op, a, b, {mHi, mLo});
        runOp(op, a, b, cyc, held);
        check($sformatf("rnd%0d_cycles", i), 64'(cyc), 64'(refCycles(op)));
        check($sformatf("rnd%0d_op%0d_hilo", i, op), {bus.HI, bus.LO}, exp);
        {mHi, mLo} = exp;
      end
    end

    check("protocol_errors", 64'(nProtocolErr), 64'd0);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
Multiply/divide unit with HI/LO registers for the execute stage of the pipelined MIPS core. It sits beside the E-stage ALU and consumes the forwarded rs/rt operands that the E stage produces. It runs multi-cycle mult/multu/div/divu operations and single-cycle mthi/mtlo writes. Its Busy output feeds the stall controller, which holds any later md instruction in D.

Parameters:
MULT_CYCLES, 5, cycles Busy stays high for mult/multu (range 1..15)
DIV_CYCLES, 10, cycles Busy stays high for div/divu (range 1..15)

Ports:
Clk  input  1  pipeline clock
Reset  input  1  asynchronous, active-low reset
Start  input  1  E-stage instruction is mult/multu/div/divu (madd/maddu/msub/msubu when enabled); one-cycle pulse
MDOp  input  3  operation select; encodings come from md_pkg
A  input  32  forwarded rs operand
B  input  32  forwarded rt operand
WriteHL  input  1  E-stage instruction is mthi/mtlo; MDOp selects which register
Busy  output  1  operation in flight (registered)
HI  output  32  HI register, feeds mfhi
LO  output  32  LO register, feeds mflo

Behaviour:
- Reset low (async): state=IDLE, counter=0, Busy=0, HI=0, LO=0, shadow result=0. Reset mid-operation aborts the operation; HI/LO do not receive the pending result.
- FSM has two states: IDLE and BUSY.
- IDLE, Start=1 at edge k:
  - Compute the 64-bit result from A and B, store it in a shadow register.
  - Load counter with MULT_CYCLES or DIV_CYCLES.
  - Set Busy=1 and go to BUSY.
- BUSY: counter decrements on each edge. On the edge where counter==1:
  - Write HI/LO from the shadow register.
  - Set Busy=0 and return to IDLE.
  - Busy is high for exactly N cycles (k+1..k+N). The new HI/LO are visible in cycle k+N+1, the same cycle Busy is low.
- mult: signed 32x32 to 64; HI=upper 32 bits, LO=lower 32 bits. multu: unsigned.
- div: signed; LO=quotient truncated toward zero, HI=remainder with the sign of the dividend. divu: unsigned.
- Divide by zero: LO=32'hFFFFFFFF, HI=A. Busy lasts DIV_CYCLES as normal.
- Signed overflow 0x80000000 / -1: LO=0x80000000, HI=0.
- mthi/mtlo (WriteHL=1, state IDLE): HI or LO := A at the next edge; Busy stays 0.
- Start or WriteHL while BUSY: ignored, HI/LO unaffected. The stall unit must prevent this. A bench assertion flags it.
- Start and WriteHL both high: Start wins; WriteHL is ignored.
- Invalid MDOp with Start: treated as a no-op; no Busy.
- HI/LO read combinationally. During BUSY they hold the previous values; the stall unit blocks mfhi/mflo while Start|Busy.

Optional Feature:
Macro MD_MADD_EN.
- Defined: MDOp adds MADD, MADDU, MSUB, MSUBU. Result = {HI,LO} +/- product, computed against the HI/LO values at commit time. Latency is MULT_CYCLES.
- Undefined: these encodings are invalid and treated as no-ops. The accumulate adder and its mux are absent.

Decomposition:
- md_pkg holds:
  - MDOp encodings: MD_MULT=0, MD_MULTU=1, MD_DIV=2, MD_DIVU=3, MD_MTHI=4, MD_MTLO=5, MD_MADD=6, MD_MSUB=7.
  - Unsigned accumulate variants, selected by a package constant bit when MD_MADD_EN is defined.
  - Default cycle constants and the 64-bit result typedef.
- One natural sub-module, md_calc: combinational 64-bit mult/div result from MDOp, A and B, including the divide-by-zero and overflow rules.
- md_unit keeps the FSM, counter, shadow register and HI/LO.

Test Plan:
- mult A=0xFFFFFFFF, B=2 -> Busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE. multu with the same operands -> HI=0x00000001, LO=0xFFFFFFFE.
- div A=0xFFFFFFF9 (-7), B=2 -> Busy high 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu A=7, B=2 -> LO=3, HI=1.
- divu A=0x1234, B=0 -> after 10 cycles LO=0xFFFFFFFF, HI=0x1234. div 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- mthi A=0xDEADBEEF, then mtlo A=0x5 -> HI=0xDEADBEEF and LO=5 one edge each; Busy never asserts.
- Start mult 3x4, then drive Reset low at busy cycle 2 -> Busy=0, HI=LO=0 immediately; after release, no stale commit occurs.
- (MD_MADD_EN) HI=0, LO=0xFFFFFFFF, madd A=1, B=1 -> HI=1, LO=0 after 5 cycles. msub A=1, B=1 -> HI=0, LO=0xFFFFFFFF.
